// File: rtl/audio_note_sequencer.sv
// Square-wave melody player: walks a note table in synchronous memory and feeds
// one sample per accepted write into the audio controller FIFO.
//
//  state | meaning
//  IDLE  | waiting for start, no writes
//  FETCH | note_rd high, memory read in flight
//  LOAD  | capture entry, decide play / end marker
//  PLAY  | one sample per accepted write until the note's sample budget runs out
//  NEXT  | advance address or treat the last address as an end marker
module audio_note_sequencer #(
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] AMPLITUDE    = 32'd10000000,
    parameter int          UNIT_SAMPLES = 4800
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              mute,
    output logic [ADDR_W-1:0] note_addr,
    output logic              note_rd,
    input  logic [15:0]       note_data,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [31:0]       left_channel_audio_out,
    output logic [31:0]       right_channel_audio_out,
    output logic              busy,
    output logic              done
);

    localparam int                SL_W      = $clog2(255 * UNIT_SAMPLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [31:0]       NEG_AMP   = -AMPLITUDE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_NEXT
    } state_t;

    state_t          state;
    logic [7:0]      half_period;
    logic [7:0]      half_cnt;
    logic [SL_W-1:0] samples_left;
    logic            phase_neg;
    logic [31:0]     sample;
    logic            half_wrap;

    function automatic logic [31:0] sample_val(input logic muted, input logic [7:0] hp,
                                               input logic neg);
        logic [31:0] v;
        if (muted || hp == 8'd0)
            v = '0;
        else if (neg)
            v = NEG_AMP;
        else
            v = AMPLITUDE;
        return v;
    endfunction

    assign write_audio_out         = (state == S_PLAY) && audio_out_allowed && !stop;
    assign busy                    = (state != S_IDLE);
    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;
    assign half_wrap               = (half_cnt == half_period - 8'd1);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            note_addr    <= '0;
            note_rd      <= 1'b0;
            done         <= 1'b0;
            sample       <= '0;
            half_period  <= '0;
            half_cnt     <= '0;
            samples_left <= '0;
            phase_neg    <= 1'b0;
        end else begin
            note_rd <= 1'b0;
            done    <= 1'b0;
            if (stop) begin
                state     <= S_IDLE;
                note_addr <= '0;
                sample    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            note_addr <= '0;
                            note_rd   <= 1'b1;
                            state     <= S_FETCH;
                        end
                    end
                    S_FETCH: state <= S_LOAD;
                    S_LOAD: begin
                        half_period <= note_data[15:8];
                        if (note_data[7:0] == 8'd0) begin
                            if (loop_en) begin
                                note_addr <= '0;
                                note_rd   <= 1'b1;
                                state     <= S_FETCH;
                            end else begin
                                done   <= 1'b1;
                                sample <= '0;
                                state  <= S_IDLE;
                            end
                        end else begin
                            samples_left <= SL_W'(note_data[7:0]) * SL_W'(UNIT_SAMPLES);
                            half_cnt     <= '0;
                            phase_neg    <= 1'b0;
                            // first sample must already be on the bus in the first PLAY cycle
                            sample       <= sample_val(mute, note_data[15:8], 1'b0);
                            state        <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (write_audio_out) begin
                            samples_left <= samples_left - SL_W'(1);
                            if (half_wrap) begin
                                half_cnt  <= '0;
                                phase_neg <= ~phase_neg;
                                sample    <= sample_val(mute, half_period, ~phase_neg);
                            end else begin
                                half_cnt <= half_cnt + 8'd1;
                                sample   <= sample_val(mute, half_period, phase_neg);
                            end
                            if (samples_left == SL_W'(1))
                                state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (note_addr == LAST_ADDR) begin
                            if (loop_en) begin
                                note_addr <= '0;
                                note_rd   <= 1'b1;
                                state     <= S_FETCH;
                            end else begin
                                done   <= 1'b1;
                                sample <= '0;
                                state  <= S_IDLE;
                            end
                        end else begin
                            note_addr <= note_addr + 1'b1;
                            note_rd   <= 1'b1;
                            state     <= S_FETCH;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Scoreboard bench for audio_note_sequencer: expected samples are queued by the
// stimulus thread and popped by a negedge monitor on every accepted write.
module tb_audio_note_sequencer;

    localparam logic [31:0] AP = 32'h0098_9680;
    localparam logic [31:0] AN = 32'hFF67_6980;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        mute = 1'b0;
    logic [9:0]  note_addr;
    logic        note_rd;
    logic [15:0] note_data = '0;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        busy;
    logic        done;

    logic        allow_lvl = 1'b1;
    logic        tog_en = 1'b0;
    logic        tog_bit = 1'b0;
    assign audio_out_allowed = tog_en ? tog_bit : allow_lvl;

    audio_note_sequencer #(
        .ADDR_W(10),
        .AMPLITUDE(32'd10000000),
        .UNIT_SAMPLES(4)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
        .mute(mute),
        .note_addr(note_addr),
        .note_rd(note_rd),
        .note_data(note_data),
        .audio_out_allowed(audio_out_allowed),
        .write_audio_out(write_audio_out),
        .left_channel_audio_out(left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .busy(busy),
        .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [15:0] mem [0:1023];
    always @(posedge CLOCK_50) if (note_rd) note_data <= mem[note_addr];

    int cyc = 0;
    int base = 0;
    always @(posedge CLOCK_50) begin
        cyc <= cyc + 1;
        if (tog_en) tog_bit <= ~tog_bit;
    end

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_q [$];
    int rd_rel [$];
    int rd_addr [$];
    int wr_rel [$];
    int wr_cnt = 0;
    int done_cnt = 0;
    int done_rel = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int q_at(input int q [$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    always @(negedge CLOCK_50) begin
        if (note_rd) begin
            rd_rel.push_back(cyc - base);
            rd_addr.push_back(int'(note_addr));
        end
        if (done) begin
            done_cnt++;
            done_rel = cyc - base;
        end
        if (write_audio_out) begin
            wr_cnt++;
            wr_rel.push_back(cyc - base);
            check("wr_when_allowed", 32'(audio_out_allowed), 32'd1);
            check("right_eq_left", right_channel_audio_out, left_channel_audio_out);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL extra_write: got sample %h expected no write", left_channel_audio_out);
            end else begin
                check("sample", left_channel_audio_out, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic load_tbl(input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0] = e0; mem[1] = e1; mem[2] = e2; mem[3] = e3;
    endtask

    task automatic clear_logs();
        rd_rel.delete(); rd_addr.delete(); wr_rel.delete();
        wr_cnt = 0; done_cnt = 0; done_rel = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        base = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin tick(); n++; end
        tick(); tick();
        check("done_once", 32'(done_cnt), 32'd1);
    endtask

    task automatic wait_writes(input int count, input int budget);
        int n = 0;
        while (wr_cnt < count && n < budget) begin tick(); n++; end
        check("write_count_reached", 32'(wr_cnt >= count), 32'd1);
    endtask

    task automatic wait_rel(input int rel);
        int n = 0;
        while ((cyc - base) < rel && n < 50) begin tick(); n++; end
        check("reach_cycle", 32'(cyc - base), 32'(rel));
    endtask

    initial begin
        load_tbl(16'h0201, 16'h0000, 16'h0000, 16'h0000);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_write", 32'(write_audio_out), 32'd0);
        check("rst_addr", 32'(note_addr), 32'd0);
        check("rst_left", left_channel_audio_out, 32'd0);
        check("rst_done_rd", {30'd0, done, note_rd}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // basic note, full-rate FIFO
        clear_logs();
        exp_q.push_back(AP); exp_q.push_back(AP); exp_q.push_back(AN); exp_q.push_back(AN);
        pulse_start();
        wait_done(40);
        check("t1_rd0_cycle", 32'(q_at(rd_rel, 0)), 32'd1);
        check("t1_rd1_cycle", 32'(q_at(rd_rel, 1)), 32'd8);
        check("t1_first_wr", 32'(q_at(wr_rel, 0)), 32'd3);
        check("t1_last_wr", 32'(q_at(wr_rel, 3)), 32'd6);
        check("t1_wr_cnt", 32'(wr_cnt), 32'd4);
        check("t1_done_cycle", 32'(done_rel), 32'd10);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // same note with FIFO space every other cycle
        clear_logs();
        tog_en = 1'b1;
        exp_q.push_back(AP); exp_q.push_back(AP); exp_q.push_back(AN); exp_q.push_back(AN);
        pulse_start();
        wait_done(60);
        tog_en = 1'b0;
        check("t2_wr_cnt", 32'(wr_cnt), 32'd4);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // rest, muted note, then unmuted note
        clear_logs();
        load_tbl(16'h0001, 16'h0101, 16'h0101, 16'h0000);
        mute = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'd0);
        exp_q.push_back(AP); exp_q.push_back(AN); exp_q.push_back(AP); exp_q.push_back(AN);
        pulse_start();
        wait_writes(8, 80);
        mute = 1'b0;
        wait_done(80);
        check("t3_wr_cnt", 32'(wr_cnt), 32'd12);
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // looping on the end marker
        clear_logs();
        load_tbl(16'h0101, 16'h0000, 16'h0000, 16'h0000);
        loop_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(AP); exp_q.push_back(AN); exp_q.push_back(AP); exp_q.push_back(AN);
        end
        pulse_start();
        wait_writes(8, 80);
        stop = 1'b1;
        check("t4_busy_loop", 32'(busy), 32'd1);
        check("t4_no_done", 32'(done_cnt), 32'd0);
        check("t4_rd_addr1", 32'(q_at(rd_addr, 1)), 32'd1);
        check("t4_rd_addr2", 32'(q_at(rd_addr, 2)), 32'd0);
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        check("t4_busy_stopped", 32'(busy), 32'd0);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // stop on the second write of a note
        clear_logs();
        load_tbl(16'h0201, 16'h0000, 16'h0000, 16'h0000);
        exp_q.push_back(AP);
        pulse_start();
        wait_rel(4);
        stop = 1'b1;
        #1;
        check("t5_write_in_stop", 32'(write_audio_out), 32'd0);
        tick();
        stop = 1'b0;
        check("t5_busy_after_stop", 32'(busy), 32'd0);
        check("t5_addr_cleared", 32'(note_addr), 32'd0);
        check("t5_sample_cleared", left_channel_audio_out, 32'd0);
        repeat (12) tick();
        check("t5_no_done", 32'(done_cnt), 32'd0);
        check("t5_wr_cnt", 32'(wr_cnt), 32'd1);
        clear_logs();
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("t5_start_stop_busy", 32'(busy), 32'd0);
        tick();
        check("t5_start_stop_no_rd", 32'(rd_rel.size()), 32'd0);

        // asynchronous reset mid-note, then replay
        clear_logs();
        exp_q.delete();
        exp_q.push_back(AP);
        pulse_start();
        wait_rel(4);
        #2;
        reset = 1'b1;
        #1;
        check("t6_write_async", 32'(write_audio_out), 32'd0);
        check("t6_busy_async", 32'(busy), 32'd0);
        check("t6_left_async", left_channel_audio_out, 32'd0);
        check("t6_right_async", right_channel_audio_out, 32'd0);
        check("t6_addr_async", 32'(note_addr), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);
        clear_logs();
        exp_q.push_back(AP); exp_q.push_back(AP); exp_q.push_back(AN); exp_q.push_back(AN);
        pulse_start();
        wait_done(40);
        check("t6_replay_addr", 32'(q_at(rd_addr, 0)), 32'd0);
        check("t6_replay_wr_cnt", 32'(wr_cnt), 32'd4);
        check("t6_replay_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
